// File: rtl/m_unit_ctrl_if.sv
// m_unit_ctrl_if: request/result handshake bundle for the multiply/divide unit
interface m_unit_ctrl_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [2:0]      op_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic            busy_o;
    modport master (output valid_i, a_i, b_i, op_i, ready_i, input ready_o, valid_o, result_o, busy_o);
    modport slave (input valid_i, a_i, b_i, op_i, ready_i, output ready_o, valid_o, result_o, busy_o);
endinterface

// File: rtl/m_unit_ctrl.sv
// m_unit_ctrl: RV32M multiply/divide sequencer; defining M_FLUSH_EN adds the flush_i port
module m_unit_ctrl #(
    parameter int XLEN = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
`ifdef M_FLUSH_EN
    input  logic flush_i,
`endif
    m_unit_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
    state_e            state, state_nx;
    logic [5:0]        cnt, cnt_nx;
    logic [2:0]        op_q, op_nx;
    logic [XLEN-1:0]   a_q, a_nx, b_q, b_nx, r_q, r_nx, res, res_nx;
    logic              q_neg, q_neg_nx, r_neg, r_neg_nx;
    logic              a_sgn, b_sgn, div0, ovf, ge;
    logic [XLEN-1:0]   a_mag, b_mag, r_step, q_step, min_int;
    logic [XLEN:0]     rs;
    logic [2*XLEN-1:0] prod;
    assign min_int = {1'b1, {(XLEN-1){1'b0}}};
    assign a_sgn   = !bus.op_i[0] && bus.a_i[XLEN-1];
    assign b_sgn   = !bus.op_i[0] && bus.b_i[XLEN-1];
    assign a_mag   = a_sgn ? -bus.a_i : bus.a_i;
    assign b_mag   = b_sgn ? -bus.b_i : bus.b_i;
    assign div0    = bus.b_i == '0;
    assign ovf     = !bus.op_i[0] && bus.a_i == min_int && bus.b_i == '1;
    // the low 2*XLEN bits of the product of extended operands are exact for every sign mix
    assign prod    = {{XLEN{(op_q == 3'b001 || op_q == 3'b010) && a_q[XLEN-1]}}, a_q}
                   * {{XLEN{op_q == 3'b001 && b_q[XLEN-1]}}, b_q};
    // restoring step: a_q shifts the dividend out and the quotient in, r_q is the partial remainder
    assign rs      = {r_q, a_q[XLEN-1]};
    assign ge      = rs >= {1'b0, b_q};
    assign r_step  = ge ? rs[XLEN-1:0] - b_q : rs[XLEN-1:0];
    assign q_step  = {a_q[XLEN-2:0], ge};
    assign bus.ready_o  = state == IDLE;
    assign bus.valid_o  = state == DONE;
    assign bus.busy_o   = state != IDLE;
    assign bus.result_o = res;
    // next state and datapath: capture at acceptance, iterate in DIV, sign-correct on DONE entry
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op_q;
        a_nx     = a_q;
        b_nx     = b_q;
        r_nx     = r_q;
        res_nx   = res;
        q_neg_nx = q_neg;
        r_neg_nx = r_neg;
        case (state)
            IDLE: if (bus.valid_i) begin
                op_nx  = bus.op_i;
                cnt_nx = '0;
                if (!bus.op_i[2]) begin
                    state_nx = MUL;
                    a_nx     = bus.a_i;
                    b_nx     = bus.b_i;
                end else if (div0) begin
                    state_nx = DONE;
                    res_nx   = bus.op_i[1] ? bus.a_i : '1;
                end else if (ovf) begin
                    state_nx = DONE;
                    res_nx   = bus.op_i[1] ? '0 : min_int;
                end else begin
                    state_nx = DIV;
                    a_nx     = a_mag;
                    b_nx     = b_mag;
                    r_nx     = '0;
                    q_neg_nx = a_sgn ^ b_sgn;
                    r_neg_nx = a_sgn;
                end
            end
            MUL: begin
                state_nx = DONE;
                res_nx   = op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            end
            DIV: begin
                a_nx   = q_step;
                r_nx   = r_step;
                cnt_nx = cnt + 6'd1;
                if (cnt_nx == 6'(XLEN)) begin
                    state_nx = DONE;
                    res_nx   = op_q[1] ? (r_neg ? -r_step : r_step) : (q_neg ? -q_step : q_step);
                end
            end
            DONE: if (bus.ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
`ifdef M_FLUSH_EN
        if (flush_i) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            res_nx   = res;
        end
`endif
    end
    // state and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            res   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op_q  <= op_nx;
            a_q   <= a_nx;
            b_q   <= b_nx;
            r_q   <= r_nx;
            res   <= res_nx;
            q_neg <= q_neg_nx;
            r_neg <= r_neg_nx;
        end
    end
endmodule

// File: tb/tb_m_unit_ctrl.sv
// tb_m_unit_ctrl: scoreboard bench for m_unit_ctrl against an arithmetic reference model
module tb_m_unit_ctrl;
    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        logic [2:0]  op;
    } exp_t;
    logic        clk, rst_ni;
`ifdef M_FLUSH_EN
    logic        flush_i;
`endif
    int          cyc, vectors, errors, rdy_mode, n, ret, nvalid, k;
    logic [2:0]  op;
    logic [31:0] a, b;
    exp_t        sb[$];
    m_unit_ctrl_if bus();
    m_unit_ctrl dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
`ifdef M_FLUSH_EN
        .flush_i (flush_i),
`endif
        .bus     (bus)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, ux, uy, p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'b000: begin p = sx * sy; return p[31:0]; end
            3'b001: begin p = sx * sy; return p[63:32]; end
            3'b010: begin p = sx * uy; return p[63:32]; end
            3'b011: begin p = ux * uy; return p[63:32]; end
            default: ;
        endcase
        if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
        p = !o[0] ? (o[1] ? sx % sy : sx / sy) : (o[1] ? ux % uy : ux / uy);
        return p[31:0];
    endfunction
    function automatic int lat_of(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!o[2]) return 1;
        if (y == 0) return 0;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int w = 0;
        @(negedge clk);
        while (!bus.ready_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.ready_o) begin
            vectors++;
            errors++;
            $display("FAIL accept_wait: ready_o still %0b after %0d cycles, required 1", bus.ready_o, w);
            return;
        end
        bus.valid_i = 1;
        bus.op_i    = o;
        bus.a_i     = x;
        bus.b_i     = y;
        @(posedge clk);
        #1;
        e.res = model(o, x, y);
        e.acc = cyc;
        e.lat = lat_of(o, x, y);
        e.op  = o;
        sb.push_back(e);
        bus.valid_i = 0;
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        bus.op_i    = 3'($urandom);
    endtask
    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask
    task automatic monitor();
        int   first = 0;
        logic seen  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_ni) seen = 0;
            else if (bus.valid_o) begin
                if (!seen) begin
                    seen  = 1;
                    first = cyc;
                end
                if (bus.ready_i) begin
                    seen = 0;
                    vectors++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid: result %0h presented with no request outstanding", bus.result_o);
                    end else begin
                        vectors--;
                        e = sb.pop_front();
                        check($sformatf("result op=%0d", e.op), 64'(bus.result_o), 64'(e.res));
                        check($sformatf("latency op=%0d", e.op), 64'(first - e.acc), 64'(e.lat));
                    end
                end
            end
        end
    endtask
    task automatic ready_gen();
        forever begin
            @(posedge clk);
            #1;
            bus.ready_i = rdy_mode == 0 ? ($urandom_range(0, 3) != 0) : (rdy_mode == 2);
        end
    endtask
    initial begin
        vectors     = 0;
        errors      = 0;
        rdy_mode    = 0;
        bus.valid_i = 0;
        bus.a_i     = 0;
        bus.b_i     = 0;
        bus.op_i    = 0;
        bus.ready_i = 1;
`ifdef M_FLUSH_EN
        flush_i     = 0;
`endif
        rst_ni      = 1;
        #1 rst_ni   = 0;
        fork
            monitor();
            ready_gen();
        join_none
        repeat (3) @(negedge clk);
        check("reset ready_o", 64'(bus.ready_o), 1);
        check("reset valid_o", 64'(bus.valid_o), 0);
        check("reset busy_o", 64'(bus.busy_o), 0);
        check("reset result_o", 64'(bus.result_o), 0);
        rst_ni = 1;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2);
        issue(3'b101, 32'd5, 32'd0);
        issue(3'b111, 32'd5, 32'd0);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();
        @(negedge clk);
        rdy_mode = 1;
        issue(3'b101, 32'd100, 32'd7);
        n = 0;
        while (!bus.valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            check("stall valid/ready/busy", 64'({bus.valid_o, bus.ready_o, bus.busy_o}), 64'(3'b101));
            check("stall result_o", 64'(bus.result_o), 64'd14);
            @(negedge clk);
        end
        rdy_mode = 2;
        @(posedge clk);
        #2;
        ret = cyc + 1;
        issue(3'b000, $urandom, $urandom);
        check("accept after retire edge", 64'(sb[$].acc), 64'(ret + 1));
        @(negedge clk);
        rdy_mode = 0;
        drain();
        issue(3'b100, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        check("busy_o mid divide", 64'(bus.busy_o), 1);
        rst_ni = 0;
        #1;
        check("mid reset valid/busy/ready", 64'({bus.valid_o, bus.busy_o, bus.ready_o}), 64'(3'b001));
        check("mid reset result_o", 64'(bus.result_o), 0);
        sb.delete();
        @(negedge clk);
        rst_ni = 1;
        nvalid = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_o) nvalid++;
        end
        check("no valid after reset", 64'(nvalid), 0);
`ifdef M_FLUSH_EN
        issue(3'b110, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        flush_i = 1;
        @(posedge clk);
        #1;
        flush_i = 0;
        check("flush valid/ready", 64'({bus.valid_o, bus.ready_o}), 64'(2'b01));
        sb.delete();
        nvalid = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_o) nvalid++;
        end
        check("no valid after flush", 64'(nvalid), 0);
`endif
        repeat (150) begin
            op = 3'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            k  = $urandom_range(0, 9);
            b  = k == 0 ? 32'd0 : k == 1 ? 32'hFFFF_FFFF : k == 2 ? 32'($urandom_range(1, 15)) : $urandom;
            issue(op, a, b);
        end
        drain();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
